// File: rtl/icache_refill_responder_if.sv
// Line-fill handshake between the instruction cache, the refill responder and the word bus.
interface icache_refill_responder_if #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
);
  logic                     Icache_valid_req_i;
  logic [ADDR_W-1:0]        Icache_addr_i;
  logic                     fc_jump_flag_i;
  logic                     bc_Icache_ready_o;
  logic [32*LINE_WORDS-1:0] bc_Icache_data_o;
  logic                     mem_req_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic                     mem_rvalid_i;
  logic [31:0]              mem_rdata_i;
  logic                     busy_o;

  // Responder end: takes cache requests and read data, returns lines and word requests.
  modport slave (
    input  Icache_valid_req_i, Icache_addr_i, fc_jump_flag_i, mem_rvalid_i, mem_rdata_i,
    output bc_Icache_ready_o, bc_Icache_data_o, mem_req_o, mem_addr_o, busy_o
  );

  // Cache and memory end: issues requests and flushes, answers word reads.
  modport master (
    output Icache_valid_req_i, Icache_addr_i, fc_jump_flag_i, mem_rvalid_i, mem_rdata_i,
    input  bc_Icache_ready_o, bc_Icache_data_o, mem_req_o, mem_addr_o, busy_o
  );
endinterface

// File: rtl/icache_refill_responder.sv
// Instruction-cache line refill responder: fetches an aligned line as sequential word
// reads on a single-outstanding bus, returns it with a one-cycle ready pulse, supports
// flush/abort and keeps one pending request that arrives while busy.
module icache_refill_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  icache_refill_responder_if.slave  bus
);
  localparam int unsigned LINE_W = 32 * LINE_WORDS;
  localparam int unsigned OFF_W  = $clog2(4 * LINE_WORDS);
  localparam int unsigned CNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]   pend_base_q, pend_base_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                ready_q, ready_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;

  logic                flush_c;
  logic [ADDR_W-1:0]   req_base_c;
  logic                nxt_v_c;
  logic [ADDR_W-1:0]   nxt_base_c;
  logic                start_c;
  logic                leave_c;
  logic [ADDR_W-1:0]   start_base_c;

  assign flush_c    = bus.fc_jump_flag_i;
  assign req_base_c = {bus.Icache_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Pending slot as seen at the end of a busy cycle: the newest request wins, and a
  // flush of a live fetch drops an older pending request but keeps a same-cycle one.
  assign nxt_v_c    = bus.Icache_valid_req_i |
                      (pend_v_q & ~(flush_c & (state_q == FETCH)));
  assign nxt_base_c = bus.Icache_valid_req_i ? req_base_c : pend_base_q;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    line_d       = line_q;
    pend_v_d     = pend_v_q;
    pend_base_d  = pend_base_q;
    data_d       = data_q;
    ready_d      = 1'b0;
    start_c      = 1'b0;
    leave_c      = 1'b0;
    start_base_c = base_q;

    unique case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          start_c      = 1'b1;
          start_base_c = pend_base_q;
          pend_v_d     = bus.Icache_valid_req_i;
          pend_base_d  = req_base_c;
        end else if (bus.Icache_valid_req_i) begin
          start_c      = 1'b1;
          start_base_c = req_base_c;
        end
      end
      FETCH: begin
        pend_v_d    = nxt_v_c;
        pend_base_d = nxt_base_c;
        if (bus.mem_rvalid_i) begin
          line_d[32*int'(cnt_q) +: 32] = bus.mem_rdata_i;
          if (flush_c || (cnt_q == LAST_WORD)) begin
            if (!flush_c) begin
              ready_d = 1'b1;
              data_d  = line_d;
            end
            leave_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (flush_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        pend_v_d    = nxt_v_c;
        pend_base_d = nxt_base_c;
        if (bus.mem_rvalid_i) begin
          leave_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Leaving a line chains straight into a waiting request without an idle bubble.
    if (leave_c) begin
      pend_v_d = 1'b0;
      if (nxt_v_c) begin
        start_c      = 1'b1;
        start_base_c = nxt_base_c;
      end else begin
        state_d = IDLE;
      end
    end

    if (start_c) begin
      state_d = FETCH;
      base_d  = start_base_c;
      cnt_d   = '0;
    end

    mem_req_d  = (state_d != IDLE);
    mem_addr_d = mem_req_d ? (base_d + ADDR_W'({cnt_d, 2'b00})) : '0;
    busy_d     = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      line_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_base_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      line_q      <= line_d;
      pend_v_q    <= pend_v_d;
      pend_base_q <= pend_base_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req_o         = mem_req_q;
  assign bus.mem_addr_o        = mem_addr_q;
  assign bus.bc_Icache_ready_o = ready_q;
  assign bus.bc_Icache_data_o  = data_q;
  assign bus.busy_o            = busy_q;
endmodule

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for the instruction cache line-fill interface. It is the bus-controller end of the cache's valid_req/addr → ready/128-bit data handshake.
- It accepts a one-cycle refill request and fetches the aligned line as LINE_WORDS sequential 32-bit reads on a single-outstanding word bus.
- It returns the assembled line with a one-cycle ready pulse.
- It supports abort on control-flow change and holds one pending request that arrives while it is busy.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; line width = 32*LINE_WORDS, line bytes = 4*LINE_WORDS (power of two).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- Icache_valid_req_i  in  1  refill request, one-cycle pulse.
- Icache_addr_i  in  ADDR_W  request byte address, sampled with valid_req.
- fc_jump_flag_i  in  1  flush: abandon the in-flight line.
- bc_Icache_ready_o  out  1  line-return pulse.
- bc_Icache_data_o  out  32*LINE_WORDS  returned line; word i is at bits [32i+31:32i].
- mem_req_o  out  1  word read request; held until accepted.
- mem_addr_o  out  ADDR_W  word byte address.
- mem_rvalid_i  in  1  read data valid; accepts and completes the current mem_req_o.
- mem_rdata_i  in  32  read data.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, pending slot empty, abort flag cleared, word counter 0. All outputs are 0, including bc_Icache_data_o and the line buffer. Reset mid-fetch drops everything; a late mem_rvalid_i after reset is ignored in IDLE.
- Line base: base = Icache_addr_i with the low log2(4*LINE_WORDS) bits cleared. Words are fetched in ascending order base, base+4, … with no critical-word-first.
- States:
  - IDLE:
    - On valid_req, or when the pending slot is full: latch base, cnt=0, go to FETCH.
    - The pending slot takes priority and is cleared when consumed.
  - FETCH:
    - mem_req_o=1 and mem_addr_o=base+4*cnt are registered and stable while waiting.
    - mem_rvalid_i may arrive in the same cycle as mem_req_o (zero-wait) or any later cycle.
    - On rvalid, mem_rdata_i is written into line word cnt and cnt increments.
    - If that word was the last one (cnt==LINE_WORDS-1): bc_Icache_ready_o=1 in the next cycle only, and bc_Icache_data_o is updated in that same cycle. Then go to IDLE, or start the pending request directly with no idle bubble required.
    - Otherwise stay in FETCH and issue the next word in the next cycle.
  - DRAIN:
    - Entered on flush in FETCH while a word is outstanding (mem_req_o=1 and no rvalid this cycle).
    - mem_req_o stays high until mem_rvalid_i; that data is discarded.
    - Then start the pending request if there is one, else go to IDLE.
    - If flush and rvalid coincide in FETCH, the word completes, nothing is returned, and the block goes directly to IDLE or the pending request.
- Minimum latency, zero-wait memory, LINE_WORDS=4: request at cycle t → mem_req_o high t+1..t+4 → ready at t+5.
- bc_Icache_ready_o is exactly 1 cycle wide per completed, unflushed line. bc_Icache_data_o holds its value until the next completion.
- Flush rules:
  - Flush wins over completion: flush in the same cycle as the final rvalid gives no ready pulse.
  - Flush in IDLE has no effect.
  - Flush in the cycle where ready is already high does not suppress that pulse.
  - Flush in DRAIN has no additional effect.
  - Flush empties the pending slot only if that pending request arrived before the flush cycle. A valid_req in the same cycle as the flush is kept.
- Request while busy (FETCH/DRAIN):
  - The request is stored in the one-deep pending slot.
  - A newer request overwrites an older pending one; the older one is silently lost.
- mem_addr_o wraps modulo 2^ADDR_W; lines never cross the base alignment.

Test Plan:
- Zero-wait memory returning word = address, request addr 0x0000_0108 → mem_addr_o sequence 0x100, 0x104, 0x108, 0x10C → ready pulse at t+5 with data 0x0000010C_00000108_00000104_00000100; ready low at t+6.
- Memory with 3-cycle rvalid delay per word, request 0x2000 → mem_req_o/mem_addr_o stable for 3 cycles per word → ready at t+1+4*3 → exactly one pulse.
- Flush while word 1 (0x104) is outstanding with delay 2, no new request → DRAIN until that rvalid → IDLE, no ready pulse, no access to 0x108.
- Flush plus new request 0x300 in the same cycle during a fetch of 0x100 → old word drains, then fetch 0x300..0x30C → a single ready pulse carrying the 0x300 line.
- Requests 0x400 then 0x500 and 0x600 while the first is busy → line 0x400 returned, then only 0x600 fetched and returned (0x500 overwritten).
- rst=1 asserted mid-fetch at word 2 → next cycle all outputs 0; a stray rvalid ignored; a fresh request 0x100 completes normally.
